// File: rtl/catch_control.sv
`default_nettype none
// ============================================================================
// Module   : catch_control
// Purpose  : Catch / hold / deposit / cooldown control with saturating score
// Revision : 1.0
// ============================================================================
module catch_control #(
    parameter logic [9:0] PLAYER_WIDTH    = 10'd40,
    parameter logic [9:0] PLAYER_HEIGHT   = 10'd40,
    parameter logic [9:0] DROP_X_MAX      = 10'd60,
    parameter logic [7:0] DEPOSIT_CYCLES  = 8'd10,
    parameter logic [7:0] COOLDOWN_CYCLES = 8'd15,
    parameter logic [7:0] SCORE_MAX       = 8'd99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic [9:0] player_x_pos,
    input  logic [9:0] player_y_pos,
    input  logic [9:0] box_x_pos,
    input  logic [9:0] box_y_pos,
    input  logic [9:0] box_width,
    input  logic [9:0] box_height,
    input  logic       active,
    output logic       box_caught,
    output logic       player_is_holding_box,
    output logic       deposit_pulse,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLDING  = 2'd1,
        S_DEPOSIT  = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t     r_state, w_state_n;
    logic [7:0] r_cnt, w_cnt_n;
    logic [7:0] r_score, w_score_n;
    logic       r_caught, w_caught_n;
    logic       r_pulse, w_pulse_n;
    logic       r_holding, w_holding_n;

    // Edge sums carry an extra bit so objects near the right/bottom edge never wrap
    logic [10:0] w_px_end, w_py_end, w_bx_end, w_by_end;
    logic        w_overlap;

    assign w_px_end  = {1'b0, player_x_pos} + {1'b0, PLAYER_WIDTH};
    assign w_py_end  = {1'b0, player_y_pos} + {1'b0, PLAYER_HEIGHT};
    assign w_bx_end  = {1'b0, box_x_pos} + {1'b0, box_width};
    assign w_by_end  = {1'b0, box_y_pos} + {1'b0, box_height};
    assign w_overlap = ({1'b0, player_x_pos} < w_bx_end) && ({1'b0, box_x_pos} < w_px_end) &&
                       ({1'b0, player_y_pos} < w_by_end) && ({1'b0, box_y_pos} < w_py_end);

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_score_n  = r_score;
        w_caught_n = 1'b0;
        w_pulse_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (game_en && active && w_overlap) begin
                    w_state_n  = S_HOLDING;
                    w_caught_n = 1'b1;
                end
            end
            S_HOLDING: begin
                if (game_en && (player_x_pos <= DROP_X_MAX)) begin
                    w_state_n = S_DEPOSIT;
                    w_cnt_n   = 8'd0;
                end
            end
            S_DEPOSIT: begin
                if (game_en) begin
                    if (r_cnt == DEPOSIT_CYCLES - 8'd1) begin
                        w_state_n = S_COOLDOWN;
                        w_cnt_n   = 8'd0;
                        w_pulse_n = 1'b1;
                        if (r_score < SCORE_MAX) begin
                            w_score_n = r_score + 8'd1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + 8'd1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (game_en) begin
                    if (r_cnt == COOLDOWN_CYCLES - 8'd1) begin
                        w_state_n = S_IDLE;
                        w_cnt_n   = 8'd0;
                    end else begin
                        w_cnt_n = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 8'd0;
            end
        endcase
        w_holding_n = game_en ? ((w_state_n == S_HOLDING) || (w_state_n == S_DEPOSIT))
                              : r_holding;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_score   <= 8'd0;
            r_caught  <= 1'b0;
            r_pulse   <= 1'b0;
            r_holding <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_score   <= w_score_n;
            r_caught  <= w_caught_n;
            r_pulse   <= w_pulse_n;
            r_holding <= w_holding_n;
        end
    end

    assign box_caught            = r_caught;
    assign deposit_pulse         = r_pulse;
    assign player_is_holding_box = r_holding;
    assign score                 = r_score;

endmodule
`default_nettype wire
